// File: rtl/hard_png_parser.sv
// Streaming PNG container parser: signature check, chunk framing with CRC-32,
// IHDR field decode and IDAT payload forwarding tagged with the flow ip/port.
module hard_png_parser #(
  parameter logic [31:0] MAX_CHUNK_LEN = 32'h0010_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        istart,
  input  logic        ivalid,
  input  logic [7:0]  ibyte,
  input  logic [31:0] ip,
  input  logic [15:0] port,
  output logic        iready,
  output logic [31:0] o_ip,
  output logic [15:0] o_port,
  output logic        hdr_valid,
  output logic [31:0] width,
  output logic [31:0] height,
  output logic [7:0]  bit_depth,
  output logic [7:0]  colortype,
  output logic        interlace,
  output logic        odata_valid,
  output logic [7:0]  odata,
  output logic        done,
  output logic        error,
  output logic [2:0]  err_code
);

  typedef enum logic [2:0] {IDLE, SIG, LEN, TYPE, DATA, CRC, DONE, ERR} state_t;

  localparam logic [31:0] T_IHDR = 32'h4948_4452;
  localparam logic [31:0] T_IDAT = 32'h4944_4154;
  localparam logic [31:0] T_IEND = 32'h4945_4E44;

  state_t      state;
  logic [31:0] cnt, len, crc;
  logic [23:0] crc_rx, type_sh;
  logic        first_chunk, is_ihdr, is_idat, is_iend;

  logic [31:0] crc_nxt, len_nxt, type_nxt, crc_rx_nxt;
  logic [7:0]  sig_exp;

  // Bitwise-unrolled reflected CRC-32 step, one full byte per call.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  assign iready     = 1'b1;
  assign crc_nxt    = crc_byte(crc, ibyte);
  assign len_nxt    = {len[23:0], ibyte};
  assign type_nxt   = {type_sh, ibyte};
  assign crc_rx_nxt = {crc_rx, ibyte};

  always_comb begin
    sig_exp = 8'h89;
    case (cnt[2:0])
      3'd0: sig_exp = 8'h89;
      3'd1: sig_exp = 8'h50;
      3'd2: sig_exp = 8'h4E;
      3'd3: sig_exp = 8'h47;
      3'd4: sig_exp = 8'h0D;
      3'd5: sig_exp = 8'h0A;
      3'd6: sig_exp = 8'h1A;
      default: sig_exp = 8'h0A;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      cnt         <= '0;
      len         <= '0;
      crc         <= '1;
      crc_rx      <= '0;
      type_sh     <= '0;
      first_chunk <= 1'b0;
      is_ihdr     <= 1'b0;
      is_idat     <= 1'b0;
      is_iend     <= 1'b0;
      o_ip        <= '0;
      o_port      <= '0;
      hdr_valid   <= 1'b0;
      width       <= '0;
      height      <= '0;
      bit_depth   <= '0;
      colortype   <= '0;
      interlace   <= 1'b0;
      odata_valid <= 1'b0;
      odata       <= '0;
      done        <= 1'b0;
      error       <= 1'b0;
      err_code    <= '0;
    end else begin
      odata_valid <= 1'b0;
      done        <= 1'b0;
      if (istart) begin
        // Byte arriving alongside istart is deliberately dropped.
        state       <= SIG;
        cnt         <= '0;
        len         <= '0;
        crc_rx      <= '0;
        type_sh     <= '0;
        first_chunk <= 1'b1;
        is_ihdr     <= 1'b0;
        is_idat     <= 1'b0;
        is_iend     <= 1'b0;
        o_ip        <= ip;
        o_port      <= port;
        hdr_valid   <= 1'b0;
        width       <= '0;
        height      <= '0;
        bit_depth   <= '0;
        colortype   <= '0;
        interlace   <= 1'b0;
        error       <= 1'b0;
        err_code    <= '0;
      end else if (ivalid) begin
        case (state)
          SIG: begin
            if (ibyte != sig_exp) begin
              state <= ERR; error <= 1'b1; err_code <= 3'd1;
            end else if (cnt == 32'd7) begin
              state <= LEN; cnt <= '0;
            end else cnt <= cnt + 32'd1;
          end
          LEN: begin
            len <= len_nxt;
            if (cnt == 32'd3) begin
              cnt <= '0;
              if (len_nxt > MAX_CHUNK_LEN) begin
                state <= ERR; error <= 1'b1; err_code <= 3'd4;
              end else begin
                state <= TYPE; crc <= '1;
              end
            end else cnt <= cnt + 32'd1;
          end
          TYPE: begin
            crc     <= crc_nxt;
            type_sh <= type_nxt[23:0];
            if (cnt == 32'd3) begin
              cnt <= '0;
              if (first_chunk && (type_nxt != T_IHDR || len != 32'd13)) begin
                state <= ERR; error <= 1'b1; err_code <= 3'd2;
              end else begin
                is_ihdr     <= first_chunk;
                is_idat     <= (type_nxt == T_IDAT);
                is_iend     <= (type_nxt == T_IEND);
                first_chunk <= 1'b0;
                state       <= (len == 32'd0) ? CRC : DATA;
              end
            end else cnt <= cnt + 32'd1;
          end
          DATA: begin
            crc <= crc_nxt;
            if (is_ihdr) begin
              if (cnt < 32'd4)       width  <= {width[23:0], ibyte};
              else if (cnt < 32'd8)  height <= {height[23:0], ibyte};
              else if (cnt == 32'd8) bit_depth <= ibyte;
              else if (cnt == 32'd9) colortype <= ibyte;
              else if (cnt == 32'd12) interlace <= ibyte[0];
            end
            if (is_idat) begin
              odata_valid <= 1'b1;
              odata       <= ibyte;
            end
            if (cnt == len - 32'd1) begin
              state <= CRC; cnt <= '0;
            end else cnt <= cnt + 32'd1;
          end
          CRC: begin
            crc_rx <= crc_rx_nxt[23:0];
            if (cnt == 32'd3) begin
              cnt <= '0;
              if (crc_rx_nxt != ~crc) begin
                state <= ERR; error <= 1'b1; err_code <= 3'd3;
              end else if (is_iend) begin
                state <= DONE; done <= 1'b1;
              end else begin
                state <= LEN;
                if (is_ihdr) hdr_valid <= 1'b1;
              end
            end else cnt <= cnt + 32'd1;
          end
          DONE: begin
            state <= ERR; error <= 1'b1; err_code <= 3'd5;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hard_png_parser.sv
// Scoreboard bench for hard_png_parser: directed PNG streams push expected
// events, a negedge monitor pops and compares whatever the parser emits.
module tb_hard_png_parser;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        istart = 1'b0, ivalid = 1'b0;
  logic [7:0]  ibyte = '0;
  logic [31:0] ip = '0;
  logic [15:0] port = '0;
  logic        iready, hdr_valid, interlace, odata_valid, done, error;
  logic [31:0] o_ip, width, height;
  logic [15:0] o_port;
  logic [7:0]  bit_depth, colortype, odata;
  logic [2:0]  err_code;

  hard_png_parser dut (
    .clk(clk), .rstn(rstn), .istart(istart), .ivalid(ivalid), .ibyte(ibyte),
    .ip(ip), .port(port), .iready(iready), .o_ip(o_ip), .o_port(o_port),
    .hdr_valid(hdr_valid), .width(width), .height(height), .bit_depth(bit_depth),
    .colortype(colortype), .interlace(interlace), .odata_valid(odata_valid),
    .odata(odata), .done(done), .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  localparam int EV_DATA = 1, EV_HDR = 2, EV_DONE = 3, EV_ERR = 4;

  typedef struct {
    int          kind;
    logic [80:0] val;
  } ev_t;

  ev_t         sb[$];
  logic [7:0]  stream[$];
  logic [7:0]  ihdr_d[$], idat_d[$], none_d[$];
  int          n_chk = 0, n_pass = 0;

  function automatic void chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic logic [31:0] crcb(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic void exp_ev(input int k, input logic [80:0] v);
    ev_t e;
    e.kind = k; e.val = v;
    sb.push_back(e);
  endfunction

  function automatic void add_sig(input int bad);
    logic [63:0] s;
    s = 64'h89504E470D0A1A0A;
    for (int i = 0; i < 8; i++) stream.push_back(i == bad ? 8'h48 : s[63-8*i -: 8]);
  endfunction

  function automatic void add_chunk(input logic [31:0] typ, input logic [7:0] d[$],
                                    input bit ovr, input logic [31:0] crc_ovr);
    logic [31:0] l, c;
    l = d.size();
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 4; i++) stream.push_back(l[31-8*i -: 8]);
    for (int i = 0; i < 4; i++) begin
      stream.push_back(typ[31-8*i -: 8]);
      c = crcb(c, typ[31-8*i -: 8]);
    end
    foreach (d[i]) begin
      stream.push_back(d[i]);
      c = crcb(c, d[i]);
    end
    c = ovr ? crc_ovr : ~c;
    for (int i = 0; i < 4; i++) stream.push_back(c[31-8*i -: 8]);
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input bit gaps);
    while (stream.size() > 0) begin
      while (gaps && $urandom_range(0, 2) == 0) begin
        ivalid = 1'b0; ibyte = 8'($urandom); tick(1);
      end
      ibyte = stream.pop_front(); ivalid = 1'b1; tick(1);
    end
    ivalid = 1'b0; ibyte = '0;
  endtask

  // A signature-leading byte rides along with istart and must be ignored.
  task automatic start(input logic [31:0] a, input logic [15:0] p);
    istart = 1'b1; ip = a; port = p; ivalid = 1'b1; ibyte = 8'h89;
    tick(1);
    istart = 1'b0; ivalid = 1'b0; ip = '0; port = '0;
  endtask

  task automatic finish_test(input string name);
    tick(3);
    chk({name, "_sb_empty"}, sb.size(), 0);
    sb.delete();
  endtask

  function automatic void build_png(input bit bad_ihdr_crc);
    add_sig(-1);
    add_chunk(32'h49484452, ihdr_d, 1'b1, bad_ihdr_crc ? 32'h1F15C488 : 32'h1F15C489);
    add_chunk(32'h49444154, idat_d, 1'b0, 32'h0);
    add_chunk(32'h49454E44, none_d, 1'b1, 32'hAE426082);
  endfunction

  function automatic void exp_png();
    exp_ev(EV_HDR, {32'd1, 32'd1, 8'd8, 8'd6, 1'b0});
    foreach (idat_d[i]) exp_ev(EV_DATA, {73'd0, idat_d[i]});
    exp_ev(EV_DONE, '0);
  endfunction

  // Monitor: every emitted event must match the head of the scoreboard.
  initial begin
    logic prev_hdr, prev_err;
    ev_t  e;
    prev_hdr = 1'b0; prev_err = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_hdr = 1'b0; prev_err = 1'b0;
      end else begin
        for (int k = EV_DATA; k <= EV_ERR; k++) begin
          logic        hit;
          logic [80:0] v;
          hit = 1'b0; v = '0;
          case (k)
            EV_DATA: begin hit = odata_valid; v = {73'd0, odata}; end
            EV_HDR:  begin hit = hdr_valid && !prev_hdr;
                           v = {width, height, bit_depth, colortype, interlace}; end
            EV_DONE: hit = done;
            default: begin hit = error && !prev_err; v = {78'd0, err_code}; end
          endcase
          if (hit) begin
            if (sb.size() == 0) begin
              n_chk++;
              $display("FAIL unexpected_event: got kind %0d val %0h expected none", k, v);
            end else begin
              e = sb.pop_front();
              chk("event", {k[2:0], v}, {e.kind[2:0], e.val});
            end
          end
        end
        prev_hdr = hdr_valid; prev_err = error;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    ihdr_d = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01,
               8'h08, 8'h06, 8'h00, 8'h00, 8'h00};
    idat_d = '{8'h78, 8'h9C, 8'h62, 8'hF8, 8'h0F, 8'h00, 8'h01, 8'h01,
               8'h01, 8'h00, 8'hAB};

    // Reset state
    tick(2);
    chk("rst_outs", {o_ip, o_port, hdr_valid, width, height, bit_depth, colortype,
                     interlace, odata_valid, odata, done, error, err_code}, 0);
    rstn = 1'b1;
    tick(2);
    chk("iready", iready, 1);
    chk("idle_outs", {hdr_valid, done, error, odata_valid}, 0);

    // Valid 1x1 RGBA8 PNG, then a trailing byte after IEND
    exp_png();
    start(32'hC0A80001, 16'h1F90);
    chk("o_ip", o_ip, 32'hC0A80001);
    chk("o_port", o_port, 16'h1F90);
    build_png(1'b0);
    send(1'b0);
    tick(2);
    chk("valid_error", {error, err_code}, 0);
    chk("valid_hdr_sticky", hdr_valid, 1);
    chk("valid_done_low", done, 0);
    finish_test("valid");
    exp_ev(EV_ERR, 81'd5);
    stream.push_back(8'h00);
    send(1'b0);
    finish_test("after_iend");

    // Corrupted signature byte 3
    exp_ev(EV_ERR, 81'd1);
    start(32'h0A000001, 16'h0050);
    add_sig(3);
    add_chunk(32'h49484452, ihdr_d, 1'b1, 32'h1F15C489);
    send(1'b0);
    chk("badsig_hdr", hdr_valid, 0);
    chk("badsig_code", {error, err_code}, {1'b1, 3'd1});
    finish_test("badsig");

    // IHDR CRC off by one; later IDAT bytes must not be forwarded
    exp_ev(EV_ERR, 81'd3);
    start(32'h0A000002, 16'h0051);
    build_png(1'b1);
    send(1'b0);
    chk("badcrc_hdr", hdr_valid, 0);
    finish_test("badcrc");

    // First chunk IDAT
    exp_ev(EV_ERR, 81'd2);
    start(32'h0A000003, 16'h0052);
    add_sig(-1);
    add_chunk(32'h49444154, idat_d, 1'b0, 32'h0);
    send(1'b0);
    finish_test("first_idat");

    // Chunk length one above the limit
    exp_ev(EV_ERR, 81'd4);
    start(32'h0A000004, 16'h0053);
    add_sig(-1);
    stream.push_back(8'h00); stream.push_back(8'h10);
    stream.push_back(8'h00); stream.push_back(8'h01);
    send(1'b0);
    finish_test("len_max");

    // Same valid stream with random ivalid bubbles
    exp_png();
    start(32'hC0A80001, 16'h1F90);
    build_png(1'b0);
    send(1'b1);
    tick(2);
    chk("gaps_error", error, 0);
    finish_test("gaps");

    // istart mid-IDAT data, then a clean stream on a new flow
    exp_ev(EV_HDR, {32'd1, 32'd1, 8'd8, 8'd6, 1'b0});
    for (int i = 0; i < 4; i++) exp_ev(EV_DATA, {73'd0, idat_d[i]});
    start(32'h11111111, 16'h1111);
    add_sig(-1);
    add_chunk(32'h49484452, ihdr_d, 1'b1, 32'h1F15C489);
    for (int i = 0; i < 12; i++) stream.push_back(i < 8 ?
      (i == 3 ? 8'd11 : (i < 4 ? 8'h00 : (i == 4 ? 8'h49 : i == 5 ? 8'h44 : i == 6 ? 8'h41 : 8'h54)))
      : idat_d[i-8]);
    send(1'b0);
    exp_png();
    start(32'h22222222, 16'h2222);
    chk("restart_ip", {o_ip, o_port, hdr_valid}, {32'h22222222, 16'h2222, 1'b0});
    build_png(1'b0);
    send(1'b0);
    tick(2);
    chk("restart_error", error, 0);
    finish_test("restart");

    // Async reset mid-stream
    exp_ev(EV_HDR, {32'd1, 32'd1, 8'd8, 8'd6, 1'b0});
    start(32'h33333333, 16'h3333);
    add_sig(-1);
    add_chunk(32'h49484452, ihdr_d, 1'b1, 32'h1F15C489);
    stream.push_back(8'h00); stream.push_back(8'h00);
    send(1'b0);
    tick(2);
    #2 rstn = 1'b0;
    #1;
    chk("midrst_outs", {o_ip, o_port, hdr_valid, width, height, bit_depth, colortype,
                        interlace, odata_valid, odata, done, error, err_code}, 0);
    tick(2);
    rstn = 1'b1;
    finish_test("midrst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
